// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter.
package axis_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_STRB_W = DEF_DATA_W / 8;
    localparam int MAX_SRC    = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Round-robin pick: first requester after 'last', wrapping modulo num_src.
    // Falls back to 'last' when nobody requests; callers only use it when req != 0.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_SRC-1:0] req,
        input logic [2:0]         last,
        input int                 num_src
    );
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            idx = 3'((int'(last) + k) % num_src);
            if (!found && (k <= num_src) && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice. The main entry drives the registered
// outputs; the skid entry catches the beat that arrives while the output stalls.
// Upstream ready is simply "skid entry empty", which keeps full throughput.
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);

    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             main_vld_q;
    logic             skid_vld_q;
    logic             push;
    logic             advance;

    assign s_ready_o = !skid_vld_q;
    assign push      = s_valid_i && !skid_vld_q;
    assign advance   = !main_vld_q || m_ready_i;
    assign m_data_o  = main_q;
    assign m_valid_o = main_vld_q;

    // Main entry: refill from the skid entry first so beat order is preserved.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            main_vld_q <= 1'b0;
            main_q     <= '0;
        end else if (advance) begin
            if (skid_vld_q) begin
                main_vld_q <= 1'b1;
                main_q     <= skid_q;
            end else begin
                main_vld_q <= push;
                if (push) begin
                    main_q <= s_data_i;
                end
            end
        end
    end

    // Skid valid: set when a beat arrives during an output stall, cleared on drain.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            skid_vld_q <= 1'b0;
        end else if (advance) begin
            skid_vld_q <= 1'b0;
        end else if (push) begin
            skid_vld_q <= 1'b1;
        end
    end

    // Skid payload capture.
    // NOTE: payload-only register left without reset; skid_vld_q gates every use.
    always_ff @(posedge aclk) begin
        if (!advance && push) begin
            skid_q <= s_data_i;
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter: NUM_SRC AXI-Stream sources share one master
// port. A grant is held from the first beat through tlast, so packets never
// interleave. Each packet costs one arbitration cycle in IDLE.
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int STRB_W  = DATA_W / 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
    input  logic [NUM_SRC*STRB_W-1:0] s_tstrb,
    input  logic [NUM_SRC-1:0]        s_tlast,
    input  logic [NUM_SRC-1:0]        s_tvalid,
    output logic [NUM_SRC-1:0]        s_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic [STRB_W-1:0]         m_tstrb,
    output logic                      m_tlast,
    output logic [ID_W-1:0]           m_tid,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_idx
);

    localparam int PAY_W = DATA_W + STRB_W + 1 + ID_W;

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic              skid_in_ready;
    logic              sel_valid;
    logic              sel_last;
    logic              accept;
    logic [PAY_W-1:0]  pay_in;
    logic [PAY_W-1:0]  pay_out;

    assign sel_valid = (state_q == GRANT) && s_tvalid[grant_q];
    assign sel_last  = s_tlast[grant_q];
    assign accept    = sel_valid && skid_in_ready;
    assign pay_in    = {s_tdata[int'(grant_q)*DATA_W +: DATA_W],
                        s_tstrb[int'(grant_q)*STRB_W +: STRB_W],
                        sel_last, grant_q};

    assign busy      = (state_q == GRANT);
    assign grant_idx = grant_q;
    assign {m_tdata, m_tstrb, m_tlast, m_tid} = pay_out;

    // Ready is routed only to the granted source, and only while holding a grant.
    always_comb begin
        s_tready = '0;
        if (state_q == GRANT) begin
            s_tready[grant_q] = skid_in_ready;
        end
    end

    // Arbitration FSM: pick in IDLE, hold the grant until the tlast beat is accepted.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|s_tvalid) begin
                    grant_d = ID_W'(rr_pick(MAX_SRC'(s_tvalid), 3'(last_q), NUM_SRC));
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept && sel_last) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; last_grant resets so source 0 has top priority.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    axis_skid_buf #(
        .WIDTH(PAY_W)
    ) u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_data_i  (pay_in),
        .s_valid_i (sel_valid),
        .s_ready_o (skid_in_ready),
        .m_data_o  (pay_out),
        .m_valid_o (m_tvalid),
        .m_ready_i (m_tready)
    );

    a_ready_onehot: assert property (@(posedge aclk) disable iff (!aresetn) $onehot0(s_tready))
        else $fatal(1, "s_tready asserted to more than one source");

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: directed packets per source, a queue-based model
// of the arbiter (round-robin pick, packet lock, 2-deep output occupancy) checked
// every cycle, plus literal expectations for latency and output order.
module tb_axis_pkt_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int IW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
        int            tid;
    } item_t;

    typedef struct {
        int            tid;
        logic [DW-1:0] data;
    } obs_t;

    logic              aclk     = 1'b0;
    logic              aresetn  = 1'b0;
    logic [NS*DW-1:0]  s_tdata  = '0;
    logic [NS*SW-1:0]  s_tstrb  = '0;
    logic [NS-1:0]     s_tlast  = '0;
    logic [NS-1:0]     s_tvalid = '0;
    logic [NS-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [SW-1:0]     m_tstrb;
    logic              m_tlast;
    logic [IW-1:0]     m_tid;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic              busy;
    logic [IW-1:0]     grant_idx;

    axis_pkt_arbiter #(.NUM_SRC(NS), .DATA_W(DW)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_tdata   (s_tdata),
        .s_tstrb   (s_tstrb),
        .s_tlast   (s_tlast),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tstrb   (m_tstrb),
        .m_tlast   (m_tlast),
        .m_tid     (m_tid),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 aclk = ~aclk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    beat_t       src_q [NS][$];
    logic [NS-1:0] src_en = '1;
    logic [NS-1:0] hs     = '0;
    logic        pat_on = 1'b0;
    logic [3:0]  pat    = 4'b1001;

    item_t       sb[$];
    obs_t        out_log[$];
    obs_t        exp_log[$];
    logic        mdl_ok    = 1'b0;
    logic        mdl_busy  = 1'b0;
    int          mdl_grant = 0;
    int          mdl_last  = NS - 1;
    int          pkt_beats = 0;
    logic        saw_bp    = 1'b0;
    logic [NS-1:0] exp_rdy;
    logic        acc;
    logic        pop;
    item_t       it;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_next(input logic [NS-1:0] req, input int last);
        for (int k = 1; k <= NS; k++) begin
            if (req[(last + k) % NS]) return (last + k) % NS;
        end
        return last;
    endfunction

    // Model and compare, sampled mid-cycle: outputs reflect the last edge,
    // inputs are what the next edge will see.
    always @(negedge aclk) begin
        cyc++;
        if (mdl_ok) begin
            exp_rdy = '0;
            if (mdl_busy && sb.size() < 2) exp_rdy[mdl_grant] = 1'b1;
            check("busy", busy, mdl_busy);
            check("grant_idx", grant_idx, mdl_grant);
            check("s_tready", s_tready, exp_rdy);
            check("m_tvalid", m_tvalid, sb.size() > 0);
            if (sb.size() > 0) begin
                check("m_tdata", m_tdata, sb[0].data);
                check("m_tstrb", m_tstrb, sb[0].strb);
                check("m_tlast", m_tlast, sb[0].last);
                check("m_tid", m_tid, sb[0].tid);
            end
            if (mdl_busy && sb.size() == 2 && s_tready == '0) saw_bp = 1'b1;
        end
        hs = aresetn ? (s_tvalid & s_tready) : '0;
        if (!aresetn) begin
            sb.delete();
            mdl_busy  = 1'b0;
            mdl_grant = 0;
            mdl_last  = NS - 1;
            pkt_beats = 0;
            mdl_ok    = 1'b1;
        end else if (mdl_ok) begin
            acc = mdl_busy && s_tvalid[mdl_grant] && sb.size() < 2;
            pop = sb.size() > 0 && m_tready;
            if (m_tvalid && m_tready) out_log.push_back('{int'(m_tid), m_tdata});
            if (pop) void'(sb.pop_front());
            if (mdl_busy) begin
                if (acc) begin
                    it.data = s_tdata[mdl_grant*DW +: DW];
                    it.strb = s_tstrb[mdl_grant*SW +: SW];
                    it.last = s_tlast[mdl_grant];
                    it.tid  = mdl_grant;
                    sb.push_back(it);
                    pkt_beats++;
                    if (it.last) begin
                        mdl_last  = mdl_grant;
                        mdl_busy  = 1'b0;
                        pkt_beats = 0;
                    end
                end
            end else if (|s_tvalid) begin
                mdl_grant = rr_next(s_tvalid, mdl_last);
                mdl_busy  = 1'b1;
            end
        end
    end

    // Source drivers and m_tready pattern, updated just after each edge.
    always @(posedge aclk) begin
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        for (int i = 0; i < NS; i++) begin
            if (src_en[i] && src_q[i].size() > 0) begin
                s_tvalid[i]          = 1'b1;
                s_tdata[i*DW +: DW]  = src_q[i][0].data;
                s_tstrb[i*SW +: SW]  = src_q[i][0].strb;
                s_tlast[i]           = src_q[i][0].last;
            end else begin
                s_tvalid[i] = 1'b0;
            end
        end
        m_tready = pat_on ? pat[cyc % 4] : 1'b1;
    end

    task automatic send(input int src, input int n, input logic [DW-1:0] base);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = base + DW'(k);
            b.strb = 4'hF ^ SW'(k);
            b.last = (k == n - 1);
            src_q[src].push_back(b);
        end
    endtask

    task automatic expect_beat(input int tid, input logic [DW-1:0] data);
        exp_log.push_back('{tid, data});
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, out_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < out_log.size(); i++) begin
            check({name, "_tid"}, out_log[i].tid, exp_log[i].tid);
            check({name, "_data"}, out_log[i].data, exp_log[i].data);
        end
        out_log.delete();
        exp_log.delete();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        logic pending;
        n = 0;
        forever begin
            pending = mdl_busy || sb.size() > 0;
            for (int i = 0; i < NS; i++) if (src_q[i].size() > 0) pending = 1'b1;
            if (!pending || n >= budget) break;
            @(posedge aclk); #2;
            n++;
        end
        if (pending) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic wait_pkt(input string name, input int src, input int beats, input int budget);
        int n;
        n = 0;
        while (!(mdl_busy && mdl_grant == src && pkt_beats >= beats) && n < budget) begin
            @(posedge aclk); #2;
            n++;
        end
        if (n >= budget) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic flush_sources();
        for (int i = 0; i < NS; i++) src_q[i].delete();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        flush_sources();
        repeat (2) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        out_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tid", m_tid, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_s_tready", s_tready, 0);

        // 1: single 3-beat packet from source 1, bubble + skid latency of 2.
        send(1, 3, 32'hA0);
        @(posedge aclk); #2;
        n = 0;
        while (!m_tvalid && n < 10) begin
            @(posedge aclk); #2;
            n++;
        end
        check("t1_latency", n, 2);
        wait_done("t1", 50);
        check("t1_busy_after", busy, 0);
        for (int k = 0; k < 3; k++) expect_beat(1, 32'hA0 + k);
        check_log("t1");

        // 2: all sources with two 1-beat packets each, from reset priority.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < NS; s++) send(s, 1, 32'h200 + 32'(s * 16 + k));
        end
        wait_done("t2", 100);
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < NS; s++) expect_beat(s, 32'h200 + 32'(s * 16 + k));
        end
        check_log("t2");

        // 3a: source 0 joins mid-packet of source 2, source 3 silent -> 0 next.
        send(2, 4, 32'h300);
        wait_pkt("t3a", 2, 1, 50);
        send(0, 1, 32'h310);
        wait_done("t3a", 100);
        for (int k = 0; k < 4; k++) expect_beat(2, 32'h300 + k);
        expect_beat(0, 32'h310);
        check_log("t3a");

        // 3b: sources 0 and 3 join mid-packet -> 3 precedes 0.
        send(2, 4, 32'h320);
        wait_pkt("t3b", 2, 1, 50);
        send(0, 1, 32'h330);
        send(3, 1, 32'h340);
        wait_done("t3b", 100);
        for (int k = 0; k < 4; k++) expect_beat(2, 32'h320 + k);
        expect_beat(3, 32'h340);
        expect_beat(0, 32'h330);
        check_log("t3b");

        // 4: 6-beat packet under an m_tready pattern of 1,0,0,1.
        saw_bp = 1'b0;
        pat_on = 1'b1;
        send(1, 6, 32'h400);
        wait_done("t4", 200);
        pat_on = 1'b0;
        check("t4_backpressure_seen", saw_bp, 1);
        for (int k = 0; k < 6; k++) expect_beat(1, 32'h400 + k);
        check_log("t4");

        // 5: one-cycle reset while beat 3 of 5 is offered; priority restarts at 0.
        send(1, 5, 32'h500);
        wait_pkt("t5", 1, 2, 50);
        aresetn = 1'b0;
        flush_sources();
        @(posedge aclk); #2;
        aresetn = 1'b1;
        check("t5_m_tvalid", m_tvalid, 0);
        check("t5_busy", busy, 0);
        check("t5_s_tready", s_tready, 0);
        out_log.delete();
        send(3, 1, 32'h510);
        send(0, 1, 32'h520);
        send(3, 1, 32'h530);
        wait_done("t5", 100);
        expect_beat(0, 32'h520);
        expect_beat(3, 32'h510);
        expect_beat(3, 32'h530);
        check_log("t5");

        // 6: granted source pauses 5 cycles mid-packet while others wait.
        send(2, 6, 32'h600);
        wait_pkt("t6", 2, 2, 50);
        src_en[2] = 1'b0;
        send(0, 1, 32'h610);
        send(1, 1, 32'h620);
        send(3, 1, 32'h630);
        repeat (3) @(posedge aclk);
        #2;
        check("t6_hold_busy", busy, 1);
        check("t6_hold_grant", grant_idx, 2);
        check("t6_hold_others_ready", s_tready & 4'b1011, 0);
        repeat (2) @(posedge aclk);
        #2;
        src_en[2] = 1'b1;
        wait_done("t6", 100);
        for (int k = 0; k < 6; k++) expect_beat(2, 32'h600 + k);
        expect_beat(3, 32'h630);
        expect_beat(0, 32'h610);
        expect_beat(1, 32'h620);
        check_log("t6");

        repeat (2) @(posedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
